// File: rtl/shift_feed_fifo.sv
// -----------------------------------------------------------------------------
// shift_feed_fifo
//
// Byte-wide synchronous FIFO feeding an 8-bit shift register stage. A producer
// hands bytes in over a valid/ready handshake. Each buffered byte is presented
// downstream as exactly one cycle of enable=1 with dataIn valid. Pops are
// suppressed while hold is high.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   inValid  in   producer offers inData this cycle
//   inData   in   producer byte (WIDTH bits)
//   inReady  out  FIFO can accept a byte this cycle (registered count + rst only)
//   hold     in   stall: no pop at the next edge while high
//   enable   out  one-cycle pulse per popped byte (to shift register enable)
//   dataIn   out  popped byte (to shift register dataIn), holds when no pop
//   count    out  current occupancy, 0..DEPTH
//   overflow out  sticky refused-push flag (only with SHIFT_FEED_OVF_FLAG_EN)
//
// Optional feature macro: SHIFT_FEED_OVF_FLAG_EN
//   defined   -> adds the sticky overflow output
//   undefined -> no overflow port; refused pushes are silent
// -----------------------------------------------------------------------------
module shift_feed_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  input  logic [WIDTH-1:0]           inData,
  output logic                       inReady,
  input  logic                       hold,
  output logic                       enable,
  output logic [WIDTH-1:0]           dataIn,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SHIFT_FEED_OVF_FLAG_EN
  ,
  output logic                       overflow
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage array: written without reset so it maps onto RAM; the read
  // side is the registered dataIn below.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             enable_reg;
  logic [WIDTH-1:0] data_reg;

  logic push;
  logic pop;

  // Ready depends only on rst and registered occupancy, never on inValid.
  // A pop on the same edge does not free a slot for the producer when full.
  assign inReady = !rst && (count_reg != FULL_COUNT);
  assign push    = inValid && inReady;
  assign pop     = (count_reg != '0) && !hold;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= inData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count is kept
  // separately so full and empty never alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      enable_reg <= 1'b0;
      data_reg   <= '0;
    end else begin
      count_reg  <= count_next;
      enable_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        data_reg   <= mem[rd_ptr_reg];
      end
    end
  end

  assign enable = enable_reg;
  assign dataIn = data_reg;
  assign count  = count_reg;

`ifdef SHIFT_FEED_OVF_FLAG_EN
  logic overflow_reg;

  // Set on any producer offer that lands on a full FIFO; cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (inValid && (count_reg == FULL_COUNT)) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_shift_feed_fifo.sv
// -----------------------------------------------------------------------------
// tb_shift_feed_fifo
//
// Self-checking bench for shift_feed_fifo (DEPTH=4, WIDTH=8). Accepted pushes
// are predicted by the bench's own occupancy count and queued on a scoreboard;
// every enable pulse from the DUT pops the queue and compares dataIn.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_feed_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic [WIDTH-1:0] inData;
  logic             inReady;
  logic             hold;
  logic             enable;
  logic [WIDTH-1:0] dataIn;
  logic [2:0]       count;
`ifdef SHIFT_FEED_OVF_FLAG_EN
  logic             overflow;
  logic             m_ovf;
`endif

  shift_feed_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .inData  (inData),
    .inReady (inReady),
    .hold    (hold),
    .enable  (enable),
    .dataIn  (dataIn),
    .count   (count)
`ifdef SHIFT_FEED_OVF_FLAG_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] sb_q[$];
  int               m_count;
  logic             m_en;
  logic [WIDTH-1:0] m_data;
  logic             last_push;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the edge from the current inputs, take the edge, then
  // check the outputs 1ns later.
  task automatic tick();
    logic exp_push, exp_pop;
    logic [WIDTH-1:0] exp_byte;
    exp_push = inValid && !rst && (m_count != DEPTH);
    exp_pop  = !rst && (m_count != 0) && !hold;
`ifdef SHIFT_FEED_OVF_FLAG_EN
    if (!rst && inValid && (m_count == DEPTH)) m_ovf = 1'b1;
`endif
    @(posedge clk);
    if (rst) begin
      m_count = 0;
      m_en    = 1'b0;
      m_data  = '0;
      sb_q.delete();
`ifdef SHIFT_FEED_OVF_FLAG_EN
      m_ovf = 1'b0;
`endif
    end else begin
      if (exp_push) sb_q.push_back(inData);
      m_count = m_count + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
      m_en    = exp_pop;
    end
    last_push = exp_push;
    #1;
    check_eq("enable", {31'b0, enable}, {31'b0, m_en});
    if (enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_byte = sb_q.pop_front();
        m_data   = exp_byte;
        $display("deliver dataIn=%02h expected=%02h count=%0d", dataIn, exp_byte, count);
      end
    end
    check_eq("dataIn", {24'b0, dataIn}, {24'b0, m_data});
    check_eq("count", {29'b0, count}, m_count);
    check_eq("inReady", {31'b0, inReady}, {31'b0, (!rst && m_count != DEPTH)});
`ifdef SHIFT_FEED_OVF_FLAG_EN
    check_eq("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    inValid = 1'b0;
    hold    = 1'b0;
    n = 0;
    while (m_count != 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, m_count, 0);
    tick();
  endtask

  initial begin
    int n;
    int sent;
    int cyc;
    m_count = 0; m_en = 1'b0; m_data = '0; last_push = 1'b0;
`ifdef SHIFT_FEED_OVF_FLAG_EN
    m_ovf = 1'b0;
`endif
    rst = 1'b1; inValid = 1'b1; inData = 8'hFF; hold = 1'b0;

    // Reset with a producer offering data: nothing stored, outputs cleared.
    tick();
    tick();
    rst = 1'b0; inValid = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'b0, inReady}, 32'd1);
    tick();
    check_eq("empty_after_rst", {31'b0, enable}, 32'd0);

    // Single byte latency: pushed at N, presented after N+1, then held.
    inValid = 1'b1; inData = 8'h7B;
    tick();
    check_eq("single_count", {29'b0, count}, 32'd1);
    inValid = 1'b0;
    tick();
    check_eq("single_data", {24'b0, dataIn}, 32'h7B);
    tick();
    check_eq("single_hold_data", {24'b0, dataIn}, 32'h7B);

    // Fill under hold, refused fifth push, then four back-to-back pops.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      inValid = 1'b1; inData = 8'(i);
      tick();
    end
    check_eq("full_ready", {31'b0, inReady}, 32'd0);
    inData = 8'h05;
    tick();
    check_eq("refused_push", {31'b0, last_push}, 32'd0);
    inValid = 1'b0; hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("b2b_data", {24'b0, dataIn}, i);
    end
    tick();
    check_eq("b2b_end", {31'b0, enable}, 32'd0);

    // Simultaneous push/pop at count=2.
    hold = 1'b1;
    inValid = 1'b1; inData = 8'h20; tick();
    inData = 8'h21; tick();
    hold = 1'b0; inData = 8'h22; tick();
    check_eq("pushpop_count", {29'b0, count}, 32'd2);

    // Stream 0x10..0x19 with hold toggling every 3 cycles (crosses wrap).
    sent = 0; cyc = 0;
    while (sent < 10 && cyc < 100) begin
      hold = ((cyc / 3) % 2) == 1;
      inValid = 1'b1; inData = 8'(8'h10 + sent);
      tick();
      if (last_push) sent++;
      cyc++;
    end
    check_eq("stream_sent", sent, 10);
    drain("stream_drain");

    // Reset mid-operation drops stored bytes.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = 8'(8'hA0 + i);
      tick();
    end
    inValid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_no_pulse", {31'b0, enable}, 32'd0);
    end

    // Full FIFO, hold low, producer always valid: one pop per cycle.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = 8'(8'h40 + i);
      tick();
    end
    hold = 1'b0;
    sent = 4; n = 0;
    for (int i = 0; i < 12; i++) begin
      inData = 8'(8'h40 + sent);
      tick();
      if (last_push) sent++;
      if (i >= 2) begin
        check_eq("steady_enable", {31'b0, enable}, 32'd1);
        if (last_push) n++;
      end
    end
    check_eq("steady_throughput", n, 10);
    drain("full_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
